// File: rtl/cpu_sequencer.sv
// ---------------------------------------------------------------------------
// cpu_sequencer
//   Multi-cycle control FSM for a simple CPU. Each instruction goes through
//   FETCH, DECODE, EXECUTE, an optional MEM phase and WRITEBACK. The FSM then
//   advances or redirects the PC. Opcode 0 halts the machine. A watchdog moves
//   the FSM to a sticky ERROR state when a memory handshake stalls. A
//   free-running counter records how many instructions have retired.
//
// Parameters
//   TIMEOUT  max cycles spent waiting for imem_ack / dmem_ack (>= 2)
//   CNT_W    width of the retired-instruction counter
//
// Ports
//   clk, reset_n   rising-edge clock, asynchronous active-low reset
//   start          leave IDLE and begin fetching
//   imem_ack       instruction word valid this cycle (used in FETCH only)
//   opcode         instruction[31:26], sampled in DECODE
//   dmem_ack       data access complete (used in MEM only)
//   branch_taken   jump condition, sampled in EXECUTE
//   imem_req       instruction fetch request (level)
//   ir_load        load instruction register (pulse)
//   dmem_req       data memory request (level)
//   dmem_we        data memory write qualifier for dmem_req
//   reg_write_en   register file write strobe (pulse)
//   pc_inc         PC <= PC + 4 (pulse)
//   pc_load        PC <= jump target (pulse)
//   busy           FSM is sequencing an instruction
//   halted         HALT reached (sticky until reset)
//   error          handshake timeout (sticky until reset)
//   retired        completed instruction count, wraps modulo 2^CNT_W
//
// Every output is a flop loaded from the next-state decode. No path runs
// combinationally from an input to an output.
// ---------------------------------------------------------------------------
module cpu_sequencer #(
  parameter int TIMEOUT = 16,
  parameter int CNT_W   = 32
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             start,
  input  logic             imem_ack,
  input  logic [5:0]       opcode,
  input  logic             dmem_ack,
  input  logic             branch_taken,
  output logic             imem_req,
  output logic             ir_load,
  output logic             dmem_req,
  output logic             dmem_we,
  output logic             reg_write_en,
  output logic             pc_inc,
  output logic             pc_load,
  output logic             busy,
  output logic             halted,
  output logic             error,
  output logic [CNT_W-1:0] retired
);

  localparam int TO_W = $clog2(TIMEOUT);

  typedef enum logic [2:0] {
    S_IDLE, S_FETCH, S_DECODE, S_EXECUTE, S_MEM, S_WB, S_HALT, S_ERROR
  } state_t;

  typedef enum logic [1:0] {C_ALU, C_LOAD, C_STORE, C_JUMP} iclass_t;

  state_t          state, state_d;
  iclass_t         iclass;
  logic [TO_W-1:0] wait_cnt;
  logic            wait_limit;
  logic            ir_load_d, pc_inc_d, pc_load_d, retire_d;

  // Opcode 0 also lands in C_ALU here. DECODE diverts it to HALT before
  // the class is ever used.
  function automatic iclass_t classify(input logic [5:0] op);
    if (op <= 6'd23)                      return C_ALU;
    else if (op == 6'd24 || op == 6'd26)  return C_LOAD;
    else if (op == 6'd25 || op == 6'd27)  return C_STORE;
    else                                  return C_JUMP;
  endfunction

  // The limit is reached on the TIMEOUT-th waiting cycle. An ack in that
  // same cycle still completes the handshake.
  assign wait_limit = (wait_cnt == TO_W'(TIMEOUT - 1));

  // NOTE: every signal written here gets a default first, so no path can
  // leave it unassigned and infer a latch.
  always_comb begin
    state_d   = state;
    ir_load_d = 1'b0;
    pc_inc_d  = 1'b0;
    pc_load_d = 1'b0;
    retire_d  = 1'b0;
    case (state)
      S_IDLE:   if (start) state_d = S_FETCH;
      S_FETCH: begin
        if (imem_ack) begin
          state_d   = S_DECODE;
          ir_load_d = 1'b1;
        end else if (wait_limit) begin
          state_d = S_ERROR;
        end
      end
      S_DECODE: state_d = (opcode == 6'd0) ? S_HALT : S_EXECUTE;
      S_EXECUTE: begin
        case (iclass)
          C_ALU:          state_d = S_WB;
          C_LOAD, C_STORE: state_d = S_MEM;
          default: begin
            state_d   = S_FETCH;
            retire_d  = 1'b1;
            pc_load_d = branch_taken;
            pc_inc_d  = ~branch_taken;
          end
        endcase
      end
      S_MEM: begin
        if (dmem_ack) begin
          if (iclass == C_STORE) begin
            state_d  = S_FETCH;
            pc_inc_d = 1'b1;
            retire_d = 1'b1;
          end else begin
            state_d = S_WB;
          end
        end else if (wait_limit) begin
          state_d = S_ERROR;
        end
      end
      S_WB: begin
        state_d  = S_FETCH;
        retire_d = 1'b1;
      end
      S_HALT, S_ERROR: state_d = state;
      default:         state_d = S_IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments only. All flops
  // then update together from values sampled before the edge.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state        <= S_IDLE;
      iclass       <= C_ALU;
      wait_cnt     <= '0;
      imem_req     <= 1'b0;
      ir_load      <= 1'b0;
      dmem_req     <= 1'b0;
      dmem_we      <= 1'b0;
      reg_write_en <= 1'b0;
      pc_inc       <= 1'b0;
      pc_load      <= 1'b0;
      busy         <= 1'b0;
      halted       <= 1'b0;
      error        <= 1'b0;
      retired      <= '0;
    end else begin
      state <= state_d;
      if (state == S_DECODE) iclass <= classify(opcode);

      // Restart the watchdog on every entry into a handshake state.
      if ((state_d == S_FETCH || state_d == S_MEM) && state_d != state)
        wait_cnt <= '0;
      else if (state == S_FETCH || state == S_MEM)
        wait_cnt <= wait_cnt + TO_W'(1);

      imem_req     <= (state_d == S_FETCH);
      ir_load      <= ir_load_d;
      dmem_req     <= (state_d == S_MEM);
      dmem_we      <= (state_d == S_MEM) && (iclass == C_STORE);
      reg_write_en <= (state_d == S_WB);
      pc_inc       <= pc_inc_d || (state_d == S_WB);
      pc_load      <= pc_load_d;
      busy         <= (state_d == S_FETCH) || (state_d == S_DECODE) ||
                      (state_d == S_EXECUTE) || (state_d == S_MEM) ||
                      (state_d == S_WB);
      halted       <= (state_d == S_HALT);
      error        <= (state_d == S_ERROR);
      if (retire_d) retired <= retired + CNT_W'(1);
    end
  end

endmodule

// File: tb/tb_cpu_sequencer.sv
// ---------------------------------------------------------------------------
// tb_cpu_sequencer
//   Self-checking bench for cpu_sequencer. A responder process answers
//   imem_req and dmem_req after a programmable number of request cycles.
//   Delay 0 means the responder never answers. Each instruction is checked
//   against a reference model built from the opcode class. The model gives
//   the expected pulse counts, the data-request cycles, the total cycle
//   count and the retired count.
// ---------------------------------------------------------------------------
module tb_cpu_sequencer;

  localparam int TIMEOUT = 16;
  localparam int CNT_W   = 32;

  logic             clk = 1'b0;
  logic             reset_n, start, imem_ack, dmem_ack, branch_taken;
  logic [5:0]       opcode;
  logic             imem_req, ir_load, dmem_req, dmem_we, reg_write_en;
  logic             pc_inc, pc_load, busy, halted, error;
  logic [CNT_W-1:0] retired;

  int          errors = 0;
  int          checks = 0;
  int          i_delay = 1;
  int          d_delay = 1;
  bit          force_iack = 1'b0;
  logic [31:0] exp_retired = '0;

  cpu_sequencer #(.TIMEOUT(TIMEOUT), .CNT_W(CNT_W)) dut (
    .clk(clk), .reset_n(reset_n), .start(start), .imem_ack(imem_ack),
    .opcode(opcode), .dmem_ack(dmem_ack), .branch_taken(branch_taken),
    .imem_req(imem_req), .ir_load(ir_load), .dmem_req(dmem_req),
    .dmem_we(dmem_we), .reg_write_en(reg_write_en), .pc_inc(pc_inc),
    .pc_load(pc_load), .busy(busy), .halted(halted), .error(error),
    .retired(retired)
  );

  always #5 clk = ~clk;

  // Memory responder: acks on the N-th consecutive request cycle.
  initial begin
    int i_cnt = 0;
    int d_cnt = 0;
    imem_ack = 1'b0;
    dmem_ack = 1'b0;
    forever begin
      @(negedge clk);
      i_cnt = imem_req ? i_cnt + 1 : 0;
      d_cnt = dmem_req ? d_cnt + 1 : 0;
      imem_ack = force_iack || (imem_req && i_cnt == i_delay);
      dmem_ack = dmem_req && d_cnt == d_delay;
    end
  end

  // Structural invariants that must hold on every cycle.
  always @(negedge clk) begin
    if (reset_n) begin
      checks++;
      if (pc_inc && pc_load) begin
        errors++;
        $display("FAIL pc_exclusive: pc_inc=%b pc_load=%b required not both", pc_inc, pc_load);
      end
      checks++;
      if (imem_req && dmem_req) begin
        errors++;
        $display("FAIL req_exclusive: imem_req=%b dmem_req=%b required not both", imem_req, dmem_req);
      end
    end
  end

  task automatic apply_reset();
    start = 1'b0; opcode = 6'd0; branch_taken = 1'b0; force_iack = 1'b0;
    reset_n = 1'b0;
    repeat (2) @(negedge clk);
    checks++;
    if ({imem_req, ir_load, dmem_req, dmem_we, reg_write_en, pc_inc, pc_load,
         busy, halted, error} !== 10'b0) begin
      errors++;
      $display("FAIL reset_outputs: got %b required 0", {imem_req, ir_load, dmem_req,
               dmem_we, reg_write_en, pc_inc, pc_load, busy, halted, error});
    end
    checks++;
    if (retired !== '0) begin
      errors++;
      $display("FAIL reset_retired: got %0d required 0", retired);
    end
    exp_retired = '0;
    reset_n = 1'b1;
    @(negedge clk);
  endtask

  // Pulse start. The task returns at the negedge of the first FETCH cycle.
  task automatic do_start(input int first_i_delay);
    i_delay = first_i_delay;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    checks++;
    if (imem_req !== 1'b1 || busy !== 1'b1) begin
      errors++;
      $display("FAIL start_fetch: imem_req=%b busy=%b required 1 1", imem_req, busy);
    end
  endtask

  // Run one instruction. The call begins one cycle into FETCH. It ends at the
  // first cycle of the next FETCH, or at the first HALT cycle.
  task automatic run_instr(input logic [5:0] op, input logic taken,
                           input int dly_d, input int i_next);
    int  i_this = i_delay;
    int  cyc = 0, n_ir = 0, n_rw = 0, n_inc = 0, n_ld = 0, n_dreq = 0, n_dwe = 0;
    bit  seen_ir = 0, done = 0;
    bit  is_halt, is_ld, is_st, is_j, is_alu;
    int  mem, exp_cyc, exp_rw, exp_inc, exp_pld;
    opcode = op; branch_taken = taken; d_delay = dly_d;

    // Reference model, derived from the opcode class table.
    is_halt = (op == 6'd0);
    is_ld   = (op == 6'd24 || op == 6'd26);
    is_st   = (op == 6'd25 || op == 6'd27);
    is_j    = (op >= 6'd28);
    is_alu  = !is_halt && (op <= 6'd23);
    mem     = (is_ld || is_st) ? dly_d : 0;
    exp_rw  = (is_alu || is_ld) ? 1 : 0;
    exp_pld = (is_j && taken) ? 1 : 0;
    exp_inc = (is_halt || exp_pld == 1) ? 0 : 1;
    exp_cyc = is_halt ? i_this + 1 : i_this + 2 + mem + exp_rw;
    if (!is_halt) exp_retired = exp_retired + 32'd1;

    while (!done && cyc < 300) begin
      @(negedge clk);
      cyc++;
      n_ir += int'(ir_load); n_rw += int'(reg_write_en); n_inc += int'(pc_inc);
      n_ld += int'(pc_load); n_dreq += int'(dmem_req); n_dwe += int'(dmem_we);
      if (ir_load) begin
        seen_ir = 1;
        i_delay = i_next;
      end else if (seen_ir && (imem_req || halted || error)) begin
        done = 1;
      end
    end

    checks++;
    if (!done) begin
      errors++;
      $display("FAIL instr_done op=%0d: no completion within %0d cycles", op, cyc);
    end
    checks++;
    if (cyc != exp_cyc) begin
      errors++;
      $display("FAIL cycles op=%0d: got %0d required %0d", op, cyc, exp_cyc);
    end
    checks++;
    if (n_ir != 1) begin
      errors++;
      $display("FAIL ir_load op=%0d: got %0d pulses required 1", op, n_ir);
    end
    checks++;
    if (n_rw != exp_rw) begin
      errors++;
      $display("FAIL reg_write_en op=%0d: got %0d required %0d", op, n_rw, exp_rw);
    end
    checks++;
    if (n_inc != exp_inc || n_ld != exp_pld) begin
      errors++;
      $display("FAIL pc_update op=%0d: inc=%0d load=%0d required %0d %0d",
               op, n_inc, n_ld, exp_inc, exp_pld);
    end
    checks++;
    if (n_dreq != mem || n_dwe != (is_st ? mem : 0)) begin
      errors++;
      $display("FAIL dmem op=%0d: req=%0d we=%0d required %0d %0d",
               op, n_dreq, n_dwe, mem, is_st ? mem : 0);
    end
    checks++;
    if (halted !== is_halt || busy !== !is_halt || error !== 1'b0) begin
      errors++;
      $display("FAIL status op=%0d: halted=%b busy=%b error=%b required %b %b 0",
               op, halted, busy, error, is_halt, !is_halt);
    end
    checks++;
    if (retired !== exp_retired) begin
      errors++;
      $display("FAIL retired op=%0d: got %0d required %0d", op, retired, exp_retired);
    end
  endtask

  task automatic test_reset();
    reset_n = 1'b1;
    apply_reset();
  endtask

  task automatic test_rtype();
    apply_reset();
    do_start(2);
    run_instr(6'd1, 1'b0, 1, 1);
  endtask

  task automatic test_load_store();
    run_instr(6'd24, 1'b0, 3, 2);
    run_instr(6'd25, 1'b0, 3, 1);
    run_instr(6'd27, 1'b0, 1, 1);
  endtask

  task automatic test_jump();
    run_instr(6'd30, 1'b1, 1, 1);
    run_instr(6'd30, 1'b0, 1, 3);
    run_instr(6'd63, 1'b1, 1, 1);
  endtask

  task automatic test_random();
    for (int n = 0; n < 40; n++)
      run_instr(6'($urandom_range(63, 1)), 1'($urandom), $urandom_range(5, 1),
                $urandom_range(4, 1));
  endtask

  task automatic test_halt();
    int bad = 0;
    apply_reset();
    do_start(2);
    run_instr(6'd1, 1'b0, 1, 1);
    run_instr(6'd26, 1'b0, 2, 1);
    run_instr(6'd40, 1'b1, 1, 1);
    run_instr(6'd0, 1'b0, 1, 1);
    checks++;
    if (retired !== 32'd3) begin
      errors++;
      $display("FAIL halt_retired: got %0d required 3", retired);
    end
    start = 1'b1; force_iack = 1'b1;
    repeat (10) begin
      @(negedge clk);
      if (imem_req || ir_load || busy || !halted || retired !== 32'd3) bad++;
    end
    start = 1'b0; force_iack = 1'b0;
    checks++;
    if (bad != 0) begin
      errors++;
      $display("FAIL halt_sticky: got %0d disturbed cycles required 0", bad);
    end
  endtask

  task automatic test_timeout();
    int n = 1;
    // Instruction fetch that is never acknowledged.
    apply_reset();
    do_start(0);
    while (!error && n < 60) begin
      @(negedge clk);
      if (imem_req) n++;
    end
    checks++;
    if (n != TIMEOUT || error !== 1'b1 || imem_req !== 1'b0 || busy !== 1'b0) begin
      errors++;
      $display("FAIL imem_timeout: req_cycles=%0d error=%b imem_req=%b busy=%b required %0d 1 0 0",
               n, error, imem_req, busy, TIMEOUT);
    end
    // An ack on the limit cycle wins, for both handshakes.
    apply_reset();
    do_start(TIMEOUT);
    run_instr(6'd24, 1'b0, TIMEOUT, 1);
    // Data access that is never acknowledged.
    opcode = 6'd24; d_delay = 0; n = 0;
    for (int c = 0; c < 60 && !error; c++) begin
      @(negedge clk);
      if (dmem_req) n++;
    end
    checks++;
    if (n != TIMEOUT || error !== 1'b1 || dmem_req !== 1'b0 || retired !== 32'd1) begin
      errors++;
      $display("FAIL dmem_timeout: req_cycles=%0d error=%b dmem_req=%b retired=%0d required %0d 1 0 1",
               n, error, dmem_req, retired, TIMEOUT);
    end
  endtask

  task automatic test_reset_mid_mem();
    int c = 0;
    int stray = 0;
    apply_reset();
    do_start(1);
    run_instr(6'd5, 1'b0, 1, 1);
    opcode = 6'd25; d_delay = 0;
    while (!dmem_req && c < 20) begin
      @(negedge clk);
      c++;
    end
    checks++;
    if (dmem_req !== 1'b1) begin
      errors++;
      $display("FAIL mid_reach_mem: dmem_req=%b required 1", dmem_req);
    end
    #2 reset_n = 1'b0;
    #1;
    checks++;
    if (dmem_req !== 1'b0 || dmem_we !== 1'b0 || busy !== 1'b0 || retired !== '0) begin
      errors++;
      $display("FAIL mid_reset: dmem_req=%b dmem_we=%b busy=%b retired=%0d required 0 0 0 0",
               dmem_req, dmem_we, busy, retired);
    end
    @(negedge clk);
    reset_n = 1'b1;
    exp_retired = '0;
    repeat (3) begin
      @(negedge clk);
      if (imem_req || busy) stray++;
    end
    checks++;
    if (stray != 0) begin
      errors++;
      $display("FAIL mid_idle: got %0d active cycles required 0", stray);
    end
    do_start(1);
    run_instr(6'd17, 1'b0, 1, 1);
  endtask

  initial begin
    test_reset();
    test_rtype();
    test_load_store();
    test_jump();
    test_random();
    test_halt();
    test_timeout();
    test_reset_mid_mem();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
